// File: rtl/alu_seq_core.sv
// alu_seq_core: registered, width-parametrised ALU with valid/ready handshakes and a carry flag.
// Optional feature macro: ALU_SEQ_MUL_EN enables op 111 as an iterative unsigned shift-add
// multiply; when undefined, op 111 is a single-cycle PASS_A and busy is tied low.
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   request handshake; alu_op, inA, inB sampled on accept
//   out_valid/out_ready result handshake; alu_out, SKZ_cmp, carry held while stalled
//   busy                multi-cycle multiply in progress
module alu_seq_core #(
  parameter int WIDTH   = 8,
  parameter int MUL_CYC = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             SKZ_cmp,
  output logic             carry,
  output logic             busy
);
  if (MUL_CYC != WIDTH || WIDTH < 4) begin : g_bad_cfg
    $error("alu_seq_core: MUL_CYC must equal WIDTH and WIDTH must be at least 4");
  end
  logic           acc, ld, slot_free;
  logic [WIDTH:0] sum, res_n, ld_val;
  // The result register can take a new value when empty or being drained this edge.
  assign slot_free = !out_valid || out_ready;
  assign acc       = in_valid && in_ready;
  assign sum       = {1'b0, inA} + {1'b0, inB};
  // Single-cycle result as {carry, value}; op 111 falls through to PASS_A.
  always_comb begin
    case (alu_op)
      3'b010:  res_n = sum;
      3'b011:  res_n = {1'b0, inA & inB};
      3'b100:  res_n = {1'b0, inA ^ inB};
      3'b101:  res_n = {1'b0, inB};
      default: res_n = {1'b0, inA};
    endcase
  end
`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(MUL_CYC);
  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;
  state_t               state, state_n;
  logic                 is_mul;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand, prod;
  logic [WIDTH-1:0]     mplier;
  assign is_mul   = alu_op == 3'b111;
  assign in_ready = state == IDLE && slot_free;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (acc && is_mul) state_n = MUL_RUN;
      MUL_RUN:  if (cnt == CW'(MUL_CYC - 1)) state_n = MUL_DONE;
      MUL_DONE: if (slot_free) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    busy   = state != IDLE;
    ld     = (acc && !is_mul) || (state == MUL_DONE && slot_free);
    ld_val = state == MUL_DONE ? {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]} : res_n;
  end
  // Operands are captured at accept so the inputs are free to change while iterating;
  // an abort by reset is handled by the state register alone.
  always_ff @(posedge clk) begin
    if (acc && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, inA};
      mplier <= inB;
      prod   <= '0;
      cnt    <= '0;
    end else if (state == MUL_RUN) begin
      prod   <= mplier[0] ? prod + mcand : prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign in_ready = slot_free;
  always_comb begin
    busy   = 1'b0;
    ld     = acc;
    ld_val = res_n;
  end
`endif
  // A load wins over a drain, so a simultaneous drain and accept keeps out_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      SKZ_cmp   <= 1'b0;
      carry     <= 1'b0;
    end else if (ld) begin
      out_valid <= 1'b1;
      alu_out   <= ld_val[WIDTH-1:0];
      SKZ_cmp   <= ld_val[WIDTH-1:0] == '0;
      carry     <= ld_val[WIDTH];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: scoreboard bench for alu_seq_core with directed and randomized stimulus.
module tb_alu_seq_core;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]   alu_op = '0;
  logic [W-1:0] inA = '0, inB = '0;
  logic         in_ready, out_valid, SKZ_cmp, carry, busy;
  logic [W-1:0] alu_out;
  int           total = 0, bad = 0, cyc = 0;
  bit           rand_bp = 1'b0, prev_free = 1'b1, exp_busy;
  typedef struct {
    logic [W-1:0] val;
    logic         c;
    bit           mul;
    int           acc_cyc;
    bit           seen;
  } exp_t;
  exp_t q[$];

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .inA(inA), .inB(inB), .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .SKZ_cmp(SKZ_cmp), .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the opcode table, using plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   s;
    e.mul = 1'b0;
    case (op)
      3'd2: s = int'(a) + int'(b);
      3'd3: s = int'(a & b);
      3'd4: s = int'(a ^ b);
      3'd5: s = int'(b);
`ifdef ALU_SEQ_MUL_EN
      3'd7: begin s = int'(a) * int'(b); e.mul = 1'b1; end
`endif
      default: s = int'(a);
    endcase
    e.val  = W'(s % (1 << W));
    e.c    = s >= (1 << W);
    e.seen = 1'b0;
    return e;
  endfunction

  // Monitor: compares every presented result against the queue front, checks latency on
  // first appearance, and tracks when a multiply should be reporting busy.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_free = 1'b1;
      continue;
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got alu_out=%0h with no pending request (cycle %0d)", alu_out, cyc);
      end else begin
        if (prev_free) begin
          chk("latency", cyc - q[0].acc_cyc, q[0].mul ? W + 2 : 1);
          q[0].seen = 1'b1;
        end
        chk("alu_out", alu_out, q[0].val);
        chk("carry", carry, q[0].c);
        chk("skz", SKZ_cmp, q[0].val == '0);
        if (out_ready) void'(q.pop_front());
      end
      prev_free = out_ready;
    end else begin
      prev_free = 1'b1;
    end
    exp_busy = q.size() > 0 && q[$].mul && !q[$].seen && cyc > q[$].acc_cyc;
    chk("busy", busy, exp_busy);
    if (exp_busy) chk("in_ready_while_busy", in_ready, 0);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = $urandom_range(0, 3) != 0;
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    alu_op   = op;
    inA      = a;
    inB      = b;
    while (1) begin
      @(negedge clk);
      if (in_ready || n == 200) break;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed %0b for op %0d (cycle %0d)", in_ready, op, cyc);
    end else begin
      e         = model(op, a, b);
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op   = 3'($urandom);
    inA      = W'($urandom);
    inB      = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_alu_out"}, alu_out, 0);
    chk({tag, "_skz"}, SKZ_cmp, 0);
    chk({tag, "_carry"}, carry, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_reset("rst0");
    issue(3'd6, 8'hAB, 8'hFF);
    issue(3'd5, 8'h00, 8'h3C);
    issue(3'd3, 8'hF0, 8'h0F);
    issue(3'd4, 8'hA5, 8'h5A);
    issue(3'd2, 8'h0F, 8'h01);
    issue(3'd2, 8'hFF, 8'h02);
    issue(3'd2, 8'h80, 8'h80);
    issue(3'd0, 8'h5A, 8'h00);
    issue(3'd1, 8'h00, 8'h77);
    issue(3'd1, 8'h01, 8'h00);
    drain();
    out_ready = 1'b0;
    issue(3'd3, 8'hF0, 8'hFF);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(3'd4, 8'h0F, 8'h0F);
    @(negedge clk);
    chk("bp_reload_valid", out_valid, 1);
    @(posedge clk);
    #1;
    drain();
`ifdef ALU_SEQ_MUL_EN
    issue(3'd7, 8'h0C, 8'h0B);
    issue(3'd7, 8'h10, 8'h10);
    drain();
    issue(3'd7, 8'h37, 8'hC5);
    repeat (3) @(posedge clk);
    #1;
    do_reset(1);
    chk_reset("mulabort");
    repeat (15) begin
      @(negedge clk);
      chk("mulabort_no_result", out_valid, 0);
    end
    @(posedge clk);
    #1;
`else
    issue(3'd7, 8'h5A, 8'h33);
    drain();
`endif
    issue(3'd2, 8'h12, 8'h34);
    issue(3'd4, 8'h12, 8'h34);
    do_reset(2);
    chk_reset("rst_mid");
    rand_bp = 1'b1;
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
